// File: rtl/hospital_pkg.sv
// Shared types and codes for the doctor-allotment block.
package hospital_pkg;

  // Allotter response codes
  localparam logic [1:0] MSG_DOC_A = 2'b01;
  localparam logic [1:0] MSG_DOC_B = 2'b10;
  localparam logic [1:0] MSG_NONE  = 2'b11;

  // Patient symptom categories
  localparam logic [1:0] Q_GEN   = 2'b00;
  localparam logic [1:0] Q_MINOR = 2'b01;
  localparam logic [1:0] Q_MID   = 2'b10;
  localparam logic [1:0] Q_SPEC  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RELEASE,
    WAIT,
    CHECK,
    BACKOFF
  } dispatch_state_e;

  // Only the two doctor codes count as a grant; 00 is treated like "none".
  function automatic logic is_grant(input logic [1:0] msg);
    return (msg == MSG_DOC_A) || (msg == MSG_DOC_B);
  endfunction

endpackage

// File: rtl/checkin_dispatch_if.sv
// Check-in / allotter / assignment signals of the dispatch stage.
interface checkin_dispatch_if #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             patient_valid;
  logic             patient_ready;
  logic [1:0]       patient_query;
  logic [ID_W-1:0]  patient_id;
  logic [1:0]       query;
  logic             start;
  logic [1:0]       message;
  logic             assign_valid;
  logic [ID_W-1:0]  assign_id;
  logic [1:0]       assign_doctor;
  logic [CNT_W-1:0] queue_count;
  logic [7:0]       reject_count;

  // Environment side: check-in source and allotter
  modport master (
    output patient_valid, patient_query, patient_id, message,
    input  patient_ready, query, start, assign_valid, assign_id,
           assign_doctor, queue_count, reject_count
  );

  // Dispatcher side
  modport slave (
    input  patient_valid, patient_query, patient_id, message,
    output patient_ready, query, start, assign_valid, assign_id,
           assign_doctor, queue_count, reject_count
  );
endinterface

// File: rtl/checkin_fifo.sv
// Small synchronous FIFO holding {query, id} of waiting patients.
// Caller guarantees no push when full and no pop when empty.
module checkin_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // Storage array, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/checkin_dispatch.sv
// Dispatch stage: queues patients, pulses start to the allotter, and turns
// grants into assignment records; rejected heads are retried after back-off.
//
// state   | meaning
// IDLE    | waiting for a queued patient
// ISSUE   | start high for one cycle
// RELEASE | start low (allotter acts on this falling edge), load settle timer
// WAIT    | settle timer counting down
// CHECK   | sample message: grant -> assign + pop, else reject
// BACKOFF | retry timer counting down, then re-issue same head
module checkin_dispatch
  import hospital_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ID_W       = 4,
  parameter int SETTLE_CYC = 1,
  parameter int RETRY_CYC  = 4
) (
  input logic               clk,
  input logic               rst_n,
  checkin_dispatch_if.slave bus
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TMR_MAX = (SETTLE_CYC > RETRY_CYC) ? SETTLE_CYC : RETRY_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  dispatch_state_e state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             start_q;
  logic             assign_valid_q;
  logic [ID_W-1:0]  assign_id_q;
  logic [1:0]       assign_doctor_q;
  logic [7:0]       reject_cnt_q;

  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [ID_W+1:0]  head_data;
  logic [1:0]       head_query;
  logic [ID_W-1:0]  head_id;

  assign fifo_push  = bus.patient_valid && !fifo_full;
  assign head_query = head_data[ID_W+1:ID_W];
  assign head_id    = head_data[ID_W-1:0];

  checkin_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ID_W + 2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({bus.patient_query, bus.patient_id}),
    .pop_i   (assign_valid_q),
    .rdata_o (head_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencing FSM; all allotter/assignment outputs are registered here.
  // The head is popped during the assign_valid cycle, so IDLE must ignore
  // that still-present entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      tmr_q           <= '0;
      start_q         <= 1'b0;
      assign_valid_q  <= 1'b0;
      assign_id_q     <= '0;
      assign_doctor_q <= '0;
      reject_cnt_q    <= '0;
    end else begin
      start_q        <= 1'b0;
      assign_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty && !assign_valid_q) begin
            state_q <= ISSUE;
            start_q <= 1'b1;
          end
        end
        ISSUE: state_q <= RELEASE;
        RELEASE: begin
          tmr_q   <= TMR_W'(SETTLE_CYC);
          state_q <= WAIT;
        end
        WAIT: begin
          tmr_q <= tmr_q - 1'b1;
          if (tmr_q == TMR_W'(1)) state_q <= CHECK;
        end
        CHECK: begin
          if (is_grant(bus.message)) begin
            assign_valid_q  <= 1'b1;
            assign_id_q     <= head_id;
            assign_doctor_q <= bus.message;
            state_q         <= IDLE;
          end else begin
            if (reject_cnt_q != 8'hFF) reject_cnt_q <= reject_cnt_q + 8'd1;
            tmr_q   <= TMR_W'(RETRY_CYC);
            state_q <= BACKOFF;
          end
        end
        BACKOFF: begin
          tmr_q <= tmr_q - 1'b1;
          if (tmr_q == TMR_W'(1)) begin
            state_q <= ISSUE;
            start_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.patient_ready = !fifo_full;
  assign bus.query         = fifo_empty ? Q_GEN : head_query;
  assign bus.start         = start_q;
  assign bus.assign_valid  = assign_valid_q;
  assign bus.assign_id     = assign_id_q;
  assign bus.assign_doctor = assign_doctor_q;
  assign bus.queue_count   = fifo_count;
  assign bus.reject_count  = reject_cnt_q;
endmodule

// File: tb/tb_checkin_dispatch.sv
// Bench for checkin_dispatch: directed scenarios plus random traffic,
// checked against a transaction-level queue model and an allotter model.
module tb_checkin_dispatch;
  import hospital_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ID_W   = 4;
  localparam int SETTLE = 1;
  localparam int RETRY  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  checkin_dispatch_if #(.DEPTH(DEPTH), .ID_W(ID_W)) bus ();

  checkin_dispatch #(
    .DEPTH      (DEPTH),
    .ID_W       (ID_W),
    .SETTLE_CYC (SETTLE),
    .RETRY_CYC  (RETRY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [ID_W+1:0] model_q[$];
  logic [1:0]      script_q[$];
  int              rej_model  = 0;
  int              cyc        = 0;
  int              fall_cyc   = -1;
  int              starts     = 0;
  int              assigns    = 0;
  logic            start_prev = 1'b0;
  logic            av_prev    = 1'b0;
  logic            last_rej   = 1'b0;
  logic [1:0]      last_msg   = 2'b11;
  logic [1:0]      resp;
  logic            pushed;

  // Observe away from the active edge, then apply what the next edge will do.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_q.delete();
      rej_model   = 0;
      start_prev  = 1'b0;
      av_prev     = 1'b0;
      fall_cyc    = -1;
      last_rej    = 1'b0;
      bus.message = MSG_NONE;
    end else begin
      chk("queue_count", bus.queue_count, model_q.size());
      chk("patient_ready", bus.patient_ready, model_q.size() < DEPTH);
      if (model_q.size() == 0) chk("query_empty", bus.query, Q_GEN);
      else chk("query_head", bus.query, model_q[0][ID_W+1:ID_W]);

      if (bus.start) begin
        starts++;
        chk("start_width", start_prev, 1'b0);
        chk("start_nonempty", model_q.size() != 0, 1'b1);
        if (last_rej && fall_cyc >= 0) chk("backoff_gap", cyc - fall_cyc, SETTLE + RETRY + 2);
      end

      if (start_prev && !bus.start) begin
        fall_cyc = cyc;
        if (script_q.size() != 0) resp = script_q.pop_front();
        else begin
          case ($urandom_range(0, 7))
            0, 1, 2: resp = MSG_DOC_A;
            3, 4:    resp = MSG_DOC_B;
            5, 6:    resp = MSG_NONE;
            default: resp = 2'b00;
          endcase
        end
        bus.message = resp;
        last_msg    = resp;
        last_rej    = !(resp == MSG_DOC_A || resp == MSG_DOC_B);
        if (last_rej && rej_model < 255) rej_model++;
      end

      if (bus.assign_valid) begin
        assigns++;
        chk("assign_double", av_prev, 1'b0);
        chk("assign_nonempty", model_q.size() != 0, 1'b1);
        if (model_q.size() != 0) begin
          chk("assign_id", bus.assign_id, model_q[0][ID_W-1:0]);
          chk("assign_doctor", bus.assign_doctor, last_msg);
          chk("assign_latency", cyc - fall_cyc, SETTLE + 2);
        end
        last_rej = 1'b0;
      end

      pushed = bus.patient_valid && (model_q.size() < DEPTH);
      if (bus.assign_valid && model_q.size() != 0) void'(model_q.pop_front());
      if (pushed) model_q.push_back({bus.patient_query, bus.patient_id});
      start_prev = bus.start;
      av_prev    = bus.assign_valid;
    end
  end

  // ---------------- stimulus helpers (all called at posedge+1) ----------------
  task automatic push(input logic [1:0] q, input logic [ID_W-1:0] id);
    bus.patient_valid = 1'b1;
    bus.patient_query = q;
    bus.patient_id    = id;
    @(posedge clk); #1;
    bus.patient_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((model_q.size() != 0 || bus.assign_valid) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_timeout", k >= budget, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, start_at, av_at, found;
    bus.patient_valid = 1'b0;
    bus.patient_query = '0;
    bus.patient_id    = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_start", bus.start, 1'b0);
    chk("rst_query", bus.query, 2'b00);
    chk("rst_assign_valid", bus.assign_valid, 1'b0);
    chk("rst_assign_id", bus.assign_id, 0);
    chk("rst_assign_doctor", bus.assign_doctor, 2'b00);
    chk("rst_queue_count", bus.queue_count, 0);
    chk("rst_reject_count", bus.reject_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", bus.patient_ready, 1'b1);

    // 1: single patient, immediate grant, latency
    script_q.push_back(MSG_DOC_A);
    bus.patient_valid = 1'b1; bus.patient_query = Q_GEN; bus.patient_id = 4'd3;
    @(posedge clk); #1;
    bus.patient_valid = 1'b0;
    start_at = -1; av_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.start && start_at < 0) start_at = k;
      if (bus.assign_valid && av_at < 0) av_at = k;
    end
    chk("t1_start_edge", start_at, 1);
    chk("t1_assign_edge", av_at, 4 + SETTLE);
    chk("t1_assign_id", bus.assign_id, 3);
    chk("t1_assign_doctor", bus.assign_doctor, MSG_DOC_A);
    chk("t1_count", bus.queue_count, 0);

    // 2: fill queue, blocked 5th push, in-order service
    a0 = assigns;
    for (int i = 1; i <= 4; i++) push(2'($urandom_range(0, 3)), 4'(i));
    chk("t2_ready_full", bus.patient_ready, 1'b0);
    chk("t2_count_full", bus.queue_count, DEPTH);
    push(Q_MINOR, 4'd5);
    chk("t2_count_after_5th", bus.queue_count, DEPTH);
    drain(2000);
    chk("t2_assigns", assigns - a0, 4);

    // 3: two rejections then doctor B
    do_reset();
    s0 = starts; a0 = assigns;
    script_q.push_back(MSG_NONE);
    script_q.push_back(MSG_NONE);
    script_q.push_back(MSG_DOC_B);
    push(Q_SPEC, 4'd7);
    drain(500);
    chk("t3_reject_count", bus.reject_count, 2);
    chk("t3_starts", starts - s0, 3);
    chk("t3_assigns", assigns - a0, 1);
    chk("t3_doctor", bus.assign_doctor, MSG_DOC_B);
    chk("t3_id", bus.assign_id, 7);

    // 4: push coinciding with pop
    script_q.push_back(MSG_DOC_A);
    script_q.push_back(MSG_DOC_B);
    script_q.push_back(MSG_DOC_A);
    push(Q_MID, 4'd8);
    push(Q_GEN, 4'd10);
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(posedge clk); #1;
      if (bus.assign_valid) begin
        bus.patient_valid = 1'b1; bus.patient_query = Q_MINOR; bus.patient_id = 4'd9;
        @(posedge clk); #1;
        bus.patient_valid = 1'b0;
        found = 1;
      end
    end
    chk("t4_found_assign", found, 1);
    chk("t4_count_hold", bus.queue_count, 2);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(posedge clk); #1;
      if (bus.assign_valid) found = 1;
    end
    chk("t4_second_found", found, 1);
    chk("t4_second_id", bus.assign_id, 10);
    drain(500);

    // 5: async reset during WAIT
    push(Q_MID, 4'd5);
    repeat (3) @(posedge clk);
    #2;
    chk("t5_count_before", bus.queue_count, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_start", bus.start, 1'b0);
    chk("t5_count", bus.queue_count, 0);
    chk("t5_assign_valid", bus.assign_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = starts;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_start", starts - s0, 0);
    a0 = assigns;
    push(Q_GEN, 4'd6);
    drain(500);
    chk("t5_recover_assign", assigns - a0, 1);

    // 6: reject_count saturation
    do_reset();
    for (int i = 0; i < 257; i++) script_q.push_back(MSG_NONE);
    script_q.push_back(MSG_DOC_A);
    push(Q_SPEC, 4'd12);
    drain(4000);
    chk("t6_reject_sat", bus.reject_count, 255);
    chk("t6_reject_model", bus.reject_count, rej_model);
    chk("t6_id", bus.assign_id, 12);

    // 7: random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bus.patient_valid = ($urandom_range(0, 2) == 0);
      bus.patient_query = 2'($urandom_range(0, 3));
      bus.patient_id    = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    bus.patient_valid = 1'b0;
    drain(3000);
    chk("t7_reject_count", bus.reject_count, rej_model);
    chk("t7_count", bus.queue_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/checkin_dispatch.md
Name: checkin_dispatch

Overview:
- Upstream stage of the doctor-allotment block. Buffers arriving patients in a small FIFO and presents each head-of-queue patient's query code to the allotter.
- Generates the allotter's start pulse. The allotter acts on the falling edge of start.
- Captures the allotter's message response. A patient who gets a doctor is released as an assignment record; a rejected patient (no doctor free) stays at the head and is retried after a back-off.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ID_W, 4, patient ID width
- SETTLE_CYC, 1, wait cycles after the start falling edge before message is sampled (≥1)
- RETRY_CYC, 4, back-off cycles after a rejection before re-issuing (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- patient_valid  in  1  check-in request
- patient_ready  out  1  FIFO can accept (not full)
- patient_query  in  2  symptom category 00..11
- patient_id  in  ID_W  patient identifier
- query  out  2  query code to allotter (head entry)
- start  out  1  allotter trigger; falling edge = allot request
- message  in  2  allotter response: 01 doctor A, 10 doctor B, 11 none
- assign_valid  out  1  one-cycle pulse: head patient assigned
- assign_id  out  ID_W  assigned patient ID
- assign_doctor  out  2  copy of message at assignment (01/10)
- queue_count  out  $clog2(DEPTH)+1  current occupancy
- reject_count  out  8  total rejections, saturates at 255

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied.
  - FSM goes to IDLE.
  - start=0, query=00, assign_valid=0, assign_id=0, assign_doctor=00, queue_count=0, reject_count=0.
  - patient_ready=1 once out of reset.
  - Reset mid-transaction abandons it. start is forced low, which may produce one falling edge at the allotter; this is accepted.
- Push:
  - On a rising edge with patient_valid && patient_ready, {patient_query, patient_id} is written.
  - patient_ready = (queue_count != DEPTH).
- Pop:
  - Only on the assign_valid cycle.
  - Push and pop in the same cycle is legal: count unchanged. Push when full is also legal if a pop occurs that same cycle? No — patient_ready stays combinational on count only, so no push when full.
- Pointers wrap modulo DEPTH.
- query is driven from the head entry at all times when non-empty, and held stable from ISSUE through CHECK.
- FSM states:
  - IDLE: if non-empty, go to ISSUE.
  - ISSUE: start=1 for exactly one cycle, then RELEASE.
  - RELEASE: start=0 (falling edge delivered); load wait counter with SETTLE_CYC; go to WAIT.
  - WAIT: decrement the counter; at 0 go to CHECK.
  - CHECK: sample message.
    - 01 or 10: next cycle assign_valid=1, assign_id=head id, assign_doctor=message; pop; go to IDLE.
    - 11 or 00 (00 treated as rejection): increment reject_count (saturating); load back-off counter with RETRY_CYC; go to BACKOFF.
  - BACKOFF: decrement the counter; at 0 go to ISSUE with the same head entry (no reordering, head-of-line blocking by design).
- Latency: a patient accepted at edge E0 into an empty queue with an immediate grant gets assign_valid high after edge E(4+SETTLE_CYC). With defaults that is E5.
- start is only ever high in ISSUE. Pulse width is exactly 1 clk.
- assign_valid is never high in two consecutive cycles.
- assign_id and assign_doctor hold their last values when assign_valid=0.

Decomposition:
- Shared package hospital_pkg:
  - message codes MSG_DOC_A=2'b01, MSG_DOC_B=2'b10, MSG_NONE=2'b11
  - query codes Q_GEN=00, Q_MINOR=01, Q_MID=10, Q_SPEC=11
  - dispatch state enum {IDLE, ISSUE, RELEASE, WAIT, CHECK, BACKOFF}
- Sub-module checkin_fifo: synchronous FIFO with DEPTH and width 2+ID_W, async active-low reset, outputs count/full/empty.

Test Plan:
1. Reset, then push id=3, query=00; allotter model returns 01 → start high one cycle at E1→E2; assign_valid at E5 with assign_id=3, assign_doctor=01; queue_count back to 0.
2. Push 4 patients back-to-back (ids 1..4) → patient_ready=0 after the 4th; a 5th push is ignored. Each assignment pops in order 1,2,3,4 and patient_ready returns to 1 after the first pop.
3. Allotter returns 11 twice, then 10, for id=7 → reject_count=2; two back-offs of 4 cycles each; exactly 3 start pulses; single assign_valid with assign_doctor=10.
4. Simultaneous push (id=9) on the assign_valid cycle of id=8 with count=2 → count stays 2; next head is the older entry, not 9.
5. Assert rst_n low during WAIT → start=0, queue_count=0 and assign_valid=0 immediately (asynchronously); after release there are no start pulses until a new push.
6. Force reject_count to 255 via 255+ rejections → reject_count holds at 255, with no wrap to 0.
